// File: rtl/ubutterfly_inv_if.sv
// Handshake bus for the inverse butterfly: operand side (x, y, w, s) and result side (a, b, flags).
interface ubutterfly_inv_if #(
    parameter int XW = 16,
    parameter int WW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          s;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [WW-1:0] w;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] a;
    logic [XW-1:0] b;
    logic          err_div0;
    logic          inexact;

    modport master (
        output in_valid, s, x, y, w, out_ready,
        input  in_ready, out_valid, a, b, err_div0, inexact
    );

    modport slave (
        input  in_valid, s, x, y, w, out_ready,
        output in_ready, out_valid, a, b, err_div0, inexact
    );
endinterface

// File: rtl/ubutterfly_inv.sv
// Inverse unified radix-2 butterfly: recovers (a, b) from (x, y, w, s) using a serial
// restoring divider, one quotient bit per cycle, with valid/ready on both sides.
module ubutterfly_inv #(
    parameter int XW = 16,
    parameter int WW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ubutterfly_inv_if.slave    bus
);
    localparam int NW = XW + 1;
    localparam int DW = WW + 1;
    localparam int RW = WW + 2;
    localparam int HW = XW + 2;
    localparam int CW = $clog2(NW);
    localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    r_state;
    logic          r_s;
    logic [XW-1:0] r_x;
    logic [XW-1:0] r_y;
    logic [WW-1:0] r_w;
    logic [NW-1:0] r_quo;
    logic [DW-1:0] r_dmag;
    logic [RW-1:0] r_rem;
    logic          r_neg;
    logic [CW-1:0] r_cnt;
    logic [XW-1:0] r_a;
    logic [XW-1:0] r_b;
    logic          r_err;
    logic          r_inexact;

    // Halving that truncates toward zero: arithmetic shift, plus one for odd negatives.
    function automatic logic [XW-1:0] half_tz(input logic [HW-1:0] v);
        return v[XW:1] + {{(XW-1){1'b0}}, v[HW-1] & v[0]};
    endfunction

    logic [NW-1:0] w_n;
    logic [DW-1:0] w_d;
    logic [NW-1:0] w_nmag;
    logic [DW-1:0] w_dmag;
    logic          w_qneg;

    always_comb begin
        w_n    = r_s ? {r_y[XW-1], r_y} : ({r_x[XW-1], r_x} - {r_y[XW-1], r_y});
        w_d    = r_s ? {r_w[WW-1], r_w} : {r_w, 1'b0};
        w_nmag = w_n[NW-1] ? (~w_n + 1'b1) : w_n;
        w_dmag = w_d[DW-1] ? (~w_d + 1'b1) : w_d;
        w_qneg = w_n[NW-1] ^ w_d[DW-1];
    end

    logic [RW-1:0] w_rem_sh;
    logic [RW-1:0] w_rem_sub;
    logic          w_sub_ok;

    always_comb begin
        w_rem_sh  = {r_rem[RW-2:0], r_quo[NW-1]};
        w_sub_ok  = (w_rem_sh >= {1'b0, r_dmag});
        w_rem_sub = w_rem_sh - {1'b0, r_dmag};
    end

    logic [HW-1:0] w_q;
    logic [HW-1:0] w_xs;
    logic [HW-1:0] w_ys;
    logic [HW-1:0] w_sum;
    logic [HW-1:0] w_dif;
    logic [XW-1:0] w_a_fix;
    logic [XW-1:0] w_b_fix;
    logic          w_inexact_fix;

    always_comb begin
        w_q           = r_neg ? (~{1'b0, r_quo} + 1'b1) : {1'b0, r_quo};
        w_xs          = {{2{r_x[XW-1]}}, r_x};
        w_ys          = {{2{r_y[XW-1]}}, r_y};
        w_sum         = r_s ? (w_xs + w_q) : (w_xs + w_ys);
        w_dif         = w_xs - w_q;
        w_a_fix       = half_tz(w_sum);
        w_b_fix       = r_s ? half_tz(w_dif) : w_q[XW-1:0];
        w_inexact_fix = (|r_rem) | w_sum[0] | (r_s & w_dif[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_s       <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_quo     <= '0;
            r_dmag    <= '0;
            r_rem     <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_err     <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_s       <= bus.s;
                        r_x       <= bus.x;
                        r_y       <= bus.y;
                        r_w       <= bus.w;
                        r_err     <= 1'b0;
                        r_inexact <= 1'b0;
                        r_state   <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (r_w == '0) begin
                        r_err     <= 1'b1;
                        r_a       <= '0;
                        r_b       <= '0;
                        r_inexact <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_quo   <= w_nmag;
                        r_dmag  <= w_dmag;
                        r_neg   <= w_qneg;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    // Dividend bits shift out of r_quo's top as quotient bits shift in.
                    r_rem <= w_sub_ok ? w_rem_sub : w_rem_sh;
                    r_quo <= {r_quo[NW-2:0], w_sub_ok};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_a       <= w_a_fix;
                    r_b       <= w_b_fix;
                    r_inexact <= w_inexact_fix;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.err_div0  = r_err;
    assign bus.inexact   = r_inexact;
endmodule

// File: tb/tb_ubutterfly_inv.sv
// Self-checking bench for ubutterfly_inv: directed cases, reset mid-divide, then random
// transactions checked against an integer-arithmetic model of the butterfly inverse.
module tb_ubutterfly_inv;
    localparam int XW = 16;
    localparam int WW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ubutterfly_inv_if #(.XW(XW), .WW(WW)) bus ();

    ubutterfly_inv #(.XW(XW), .WW(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // SV integer / and % truncate toward zero, matching the required rounding.
    function automatic void ref_inv(input int s, input int x, input int y, input int w,
                                    output int ea, output int eb, output int eerr,
                                    output int einx);
        int q;
        int r;
        ea = 0; eb = 0; eerr = 0; einx = 0;
        if (w == 0) begin
            eerr = 1;
        end else if (s == 0) begin
            q    = (x - y) / (2 * w);
            r    = (x - y) % (2 * w);
            ea   = (x + y) / 2;
            eb   = q;
            einx = ((r != 0) || (((x + y) % 2) != 0)) ? 1 : 0;
        end else begin
            q    = y / w;
            r    = y % w;
            ea   = (x + q) / 2;
            eb   = (x - q) / 2;
            einx = ((r != 0) || (((x + q) % 2) != 0)) ? 1 : 0;
        end
    endfunction

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_out_valid"}, int'(bus.out_valid), 0);
        check({pfx, "_in_ready"},  int'(bus.in_ready), 1);
        check({pfx, "_a"},         int'($signed(bus.a)), 0);
        check({pfx, "_b"},         int'($signed(bus.b)), 0);
        check({pfx, "_err"},       int'(bus.err_div0), 0);
        check({pfx, "_inexact"},   int'(bus.inexact), 0);
    endtask

    task automatic run_txn(input int s, input int x, input int y, input int w, input int hold);
        int ea, eb, ee, ei, lat;
        ref_inv(s, x, y, w, ea, eb, ee, ei);
        @(negedge clk);
        check("in_ready_idle", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.s = s[0];
        bus.x = x[XW-1:0];
        bus.y = y[XW-1:0];
        bus.w = w[WW-1:0];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("in_ready_busy", int'(bus.in_ready), 0);
        lat = 0;
        // Junk on the operand bus while busy must be ignored.
        while (!bus.out_valid && lat < 40) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.s = 1'($urandom);
            bus.x = 16'($urandom);
            bus.y = 16'($urandom);
            bus.w = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        // Zero twiddle: done one edge after accept (two counting the accept edge).
        check("latency", lat, (ee != 0) ? 1 : 19);
        check("a", int'($signed(bus.a)), ea);
        check("b", int'($signed(bus.b)), eb);
        check("err_div0", int'(bus.err_div0), ee);
        check("inexact", int'(bus.inexact), ei);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_in_ready", int'(bus.in_ready), 0);
            check("hold_a", int'($signed(bus.a)), ea);
            check("hold_b", int'($signed(bus.b)), eb);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_clr", int'(bus.out_valid), 0);
        check("in_ready_ret", int'(bus.in_ready), 1);
        n_txn++;
        $display("txn %0d s=%0d x=%0d y=%0d w=%0d -> a=%0d b=%0d err=%0d inexact=%0d lat=%0d",
                 n_txn, s, x, y, w, $signed(bus.a), $signed(bus.b), bus.err_div0, bus.inexact, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs, rx, ry, rw;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.s = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.w = '0;
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(0, 16, 4, 3, 10);
        run_txn(1, 12, 24, 3, 0);
        run_txn(1, -10, -8, 2, 0);
        run_txn(0, -13, 3, -2, 0);
        run_txn(0, -13, -1, 2, 0);
        run_txn(0, 1234, -77, 0, 2);
        run_txn(1, 100, 50, 5, 0);
        run_txn(1, -500, 999, 0, 0);
        run_txn(0, 5, 0, 2, 0);
        run_txn(1, -32768, -32768, 1, 0);
        run_txn(0, -32768, 32767, 1, 0);
        run_txn(1, 32767, -32768, -1, 0);
        run_txn(0, 32767, -32768, -128, 0);

        // Reset while the divider is at count 8 (9 edges after accept).
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s = 1'b0;
        bus.x = 16'd16;
        bus.y = 16'd4;
        bus.w = 8'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        check("midrst_hold_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset asserted mid-divide, outputs cleared");
        run_txn(1, -10, -8, 2, 0);

        for (int i = 0; i < 40; i++) begin
            rs = int'($urandom_range(0, 1));
            rx = int'($signed(16'($urandom)));
            ry = int'($signed(16'($urandom)));
            rw = ($urandom_range(0, 9) == 0) ? 0 : int'($signed(8'($urandom)));
            run_txn(rs, rx, ry, rw, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
